dct_addsub_pipe: RTL

//   Parametrised, pipelined two's-complement add/sub array for the 8-point 2D DCT datapath.

---
 rtl/dct_addsub_pipe_pkg.sv | 25 ++
 rtl/dct_addsub_lane.sv | 38 +++
 rtl/dct_addsub_pipe.sv | 130 +++++++++++++
 3 files changed

// File: rtl/dct_addsub_pipe_pkg.sv
// Shared definitions for the DCT add/sub datapath: op encodings, Q11.4
// constants and saturation-limit helpers.
package dct_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_RSUB = 2'b10,
        OP_BFLY = 2'b11
    } op_e;

    localparam int unsigned Q_INT_BITS  = 11;
    localparam int unsigned Q_FRAC_BITS = 4;
    localparam logic [15:0] Q_ONE       = 16'h0010;

    // Limits are returned 64 bits wide; callers keep the low w bits.
    function automatic logic [63:0] sat_max(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int unsigned w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/dct_addsub_lane.sv
// One combinational lane: turns the exact WIDTH+1-bit results captured in
// stage 1 into saturated or wrapped WIDTH-bit results plus an overflow flag.
module dct_addsub_lane
    import dct_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  op_e              op,
    input  logic             sat_en,
    input  logic [WIDTH:0]   xr,
    input  logic [WIDTH:0]   xs,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] s,
    output logic             ovf
);

    localparam logic [63:0] MAX64 = sat_max(WIDTH);
    localparam logic [63:0] MIN64 = sat_min(WIDTH);

    logic ovf_r;
    logic ovf_s;

    // Sign bit of the exact value selects which rail to clamp to.
    function automatic logic [WIDTH-1:0] fit(input logic [WIDTH:0] x, input logic sat);
        if (sat && (x[WIDTH] != x[WIDTH-1]))
            return x[WIDTH] ? MIN64[WIDTH-1:0] : MAX64[WIDTH-1:0];
        return x[WIDTH-1:0];
    endfunction

    always_comb begin
        ovf_r = (xr[WIDTH] != xr[WIDTH-1]);
        ovf_s = (op == OP_BFLY) && (xs[WIDTH] != xs[WIDTH-1]);
        r     = fit(xr, sat_en);
        s     = (op == OP_BFLY) ? fit(xs, sat_en) : '0;
        ovf   = ovf_r | ovf_s;
    end

endmodule

// File: rtl/dct_addsub_pipe.sv
// Two-stage pipelined add/sub array with valid/ready on both sides and a
// saturating count of delivered beats that carried an overflow.
module dct_addsub_pipe
    import dct_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LANES = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sat_en,
    input  logic                   ovf_clr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_op,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_r,
    output logic [LANES*WIDTH-1:0] out_s,
    output logic [LANES-1:0]       out_ovf,
    output logic [CNT_W-1:0]       ovf_count
);

    logic adv1;
    logic adv2;
    logic s1_valid;
    logic s2_valid;
    op_e  op_in;
    op_e  s1_op;
    logic s1_sat;

    logic [LANES-1:0][WIDTH:0] x_r;
    logic [LANES-1:0][WIDTH:0] x_s;
    logic [LANES-1:0][WIDTH:0] s1_xr;
    logic [LANES-1:0][WIDTH:0] s1_xs;

    logic [LANES*WIDTH-1:0] r_w;
    logic [LANES*WIDTH-1:0] s_w;
    logic [LANES-1:0]       ovf_w;

    assign op_in     = op_e'(in_op);
    assign adv2      = !s2_valid || out_ready;
    assign adv1      = !s1_valid || adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_valid;

    // Exact WIDTH+1-bit results from sign-extended operands.
    always_comb begin
        logic [WIDTH:0] ae;
        logic [WIDTH:0] be;
        ae  = '0;
        be  = '0;
        x_r = '0;
        x_s = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            ae = {in_a[i*WIDTH + WIDTH - 1], in_a[i*WIDTH +: WIDTH]};
            be = {in_b[i*WIDTH + WIDTH - 1], in_b[i*WIDTH +: WIDTH]};
            case (op_in)
                OP_ADD:  x_r[i] = ae + be;
                OP_SUB:  x_r[i] = ae - be;
                OP_RSUB: x_r[i] = be - ae;
                default: begin
                    x_r[i] = ae + be;
                    x_s[i] = ae - be;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_ADD;
            s1_sat   <= 1'b0;
            s1_xr    <= '0;
            s1_xs    <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op  <= op_in;
                s1_sat <= sat_en;
                s1_xr  <= x_r;
                s1_xs  <= x_s;
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        dct_addsub_lane #(.WIDTH(WIDTH)) u_lane (
            .op     (s1_op),
            .sat_en (s1_sat),
            .xr     (s1_xr[g]),
            .xs     (s1_xs[g]),
            .r      (r_w[g*WIDTH +: WIDTH]),
            .s      (s_w[g*WIDTH +: WIDTH]),
            .ovf    (ovf_w[g])
        );
    end

    // Output registers only load on a real transfer so they hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_r    <= '0;
            out_s    <= '0;
            out_ovf  <= '0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_r   <= r_w;
                out_s   <= s_w;
                out_ovf <= ovf_w;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (ovf_clr) begin
            ovf_count <= '0;
        end else if (s2_valid && out_ready && (|out_ovf) && (ovf_count != '1)) begin
            ovf_count <= ovf_count + CNT_W'(1);
        end
    end

endmodule
